// File: rtl/clock_div_detect.sv
// Measures the period of a divided clock in clk_in cycles, recovers the
// power-of-two division factor and reports lock once the period is stable.
module clock_div_detect #(
  parameter int DIV_WIDTH    = 6,
  parameter int COUNT_WIDTH  = 32,
  parameter int MAX_PERIOD   = 65536,
  parameter int STABLE_COUNT = 4
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clk_meas,
  output logic [COUNT_WIDTH-1:0] period,
  output logic [DIV_WIDTH-1:0]   div_out,
  output logic                   meas_valid,
  output logic                   locked,
  output logic                   bad_period,
  output logic                   timeout
);

  localparam int                     MATCH_W    = $clog2(STABLE_COUNT + 1);
  localparam logic [COUNT_WIDTH-1:0] MAX_CNT    = COUNT_WIDTH'(MAX_PERIOD);
  localparam logic [MATCH_W-1:0]     MATCH_FULL = MATCH_W'(STABLE_COUNT);
  localparam longint                 DIV_LIMIT  = (longint'(1) << DIV_WIDTH) - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    MEASURE   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [2:0]             sync_q;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [MATCH_W-1:0]     match_q, match_d;
  logic                   first_q, first_d;
  logic [COUNT_WIDTH-1:0] period_q, period_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic                   valid_q, valid_d;
  logic                   locked_q, locked_d;
  logic                   bad_q, bad_d;
  logic                   timeout_q, timeout_d;

  logic                   meas_edge;
  logic                   p_pow2;
  logic                   p_bad;
  int                     p_idx;

  function automatic int msb_index(input logic [COUNT_WIDTH-1:0] v);
    int idx;
    idx = 0;
    for (int i = 0; i < COUNT_WIDTH; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  // sync1 -> sync2 -> sync3; the rising edge is seen between sync2 and sync3
  assign meas_edge = sync_q[1] & ~sync_q[2];

  // Candidate measurement is always the current count; used only on meas_edge
  assign p_pow2 = (cnt_q != '0) && ((cnt_q & (cnt_q - COUNT_WIDTH'(1))) == '0);
  assign p_idx  = msb_index(cnt_q);
  assign p_bad  = !p_pow2 || (longint'(p_idx) > DIV_LIMIT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    match_d   = match_q;
    first_d   = first_q;
    period_d  = period_q;
    div_d     = div_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    bad_d     = bad_q;
    timeout_d = timeout_q;

    if (!enable) begin
      state_d   = IDLE;
      cnt_d     = '0;
      match_d   = '0;
      first_d   = 1'b0;
      period_d  = '0;
      div_d     = '0;
      locked_d  = 1'b0;
      bad_d     = 1'b0;
      timeout_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = WAIT_EDGE;
          cnt_d   = '0;
        end
        WAIT_EDGE: begin
          if (meas_edge) begin
            state_d   = MEASURE;
            cnt_d     = COUNT_WIDTH'(1);
            first_d   = 1'b1;
            timeout_d = 1'b0;
          end else begin
            if (cnt_q != MAX_CNT) cnt_d = cnt_q + COUNT_WIDTH'(1);
            else                  timeout_d = 1'b1;
            locked_d = 1'b0;
          end
        end
        MEASURE: begin
          // An edge coinciding with a saturated count still wins over timeout
          if (meas_edge) begin
            cnt_d    = COUNT_WIDTH'(1);
            period_d = cnt_q;
            valid_d  = 1'b1;
            bad_d    = p_bad;
            if (!p_bad) div_d = DIV_WIDTH'(p_idx);
            if (first_q || (cnt_q != period_q)) match_d = MATCH_W'(1);
            else if (match_q != MATCH_FULL)     match_d = match_q + MATCH_W'(1);
            locked_d = (match_d == MATCH_FULL) && !p_bad;
            first_d  = 1'b0;
          end else if (cnt_q == MAX_CNT) begin
            state_d   = WAIT_EDGE;
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
          end else begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sync_q    <= '0;
      cnt_q     <= '0;
      match_q   <= '0;
      first_q   <= 1'b0;
      period_q  <= '0;
      div_q     <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      bad_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync_q    <= {sync_q[1:0], clk_meas};
      cnt_q     <= cnt_d;
      match_q   <= match_d;
      first_q   <= first_d;
      period_q  <= period_d;
      div_q     <= div_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      bad_q     <= bad_d;
      timeout_q <= timeout_d;
    end
  end

  assign period     = period_q;
  assign div_out    = div_q;
  assign meas_valid = valid_q;
  assign locked     = locked_q;
  assign bad_period = bad_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_clock_div_detect.sv
// Directed bench for clock_div_detect: expected measurements are queued as the
// divided clock is driven and compared whenever meas_valid pulses.
module tb_clock_div_detect;

  logic        clk_in   = 1'b0;
  logic        rst      = 1'b1;
  logic        enable   = 1'b0;
  logic        clk_meas = 1'b0;
  logic [31:0] period;
  logic [5:0]  div_out;
  logic        meas_valid;
  logic        locked;
  logic        bad_period;
  logic        timeout;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [31:0] p;
    logic [5:0]  d;
    logic        b;
    logic        l;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  always #5 clk_in = ~clk_in;

  clock_div_detect #(
    .DIV_WIDTH   (6),
    .COUNT_WIDTH (32),
    .MAX_PERIOD  (64),
    .STABLE_COUNT(4)
  ) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .enable    (enable),
    .clk_meas  (clk_meas),
    .period    (period),
    .div_out   (div_out),
    .meas_valid(meas_valid),
    .locked    (locked),
    .bad_period(bad_period),
    .timeout   (timeout)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_assert++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // One rising edge per iteration, high for hi cycles, full period per cycle
  task automatic run_clk(input int hi, input int per, input int n);
    repeat (n) begin
      clk_meas = 1'b1;
      cycles(hi);
      clk_meas = 1'b0;
      cycles(per - hi);
    end
  endtask

  task automatic push(input int p, input int d, input int b, input int l, input int reps);
    repeat (reps) exp_q.push_back({32'(p), 6'(d), 1'(b), 1'(l)});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) cycles(1);
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_period"},  64'(period),     64'd0);
    check({tag, "_div"},     64'(div_out),    64'd0);
    check({tag, "_valid"},   64'(meas_valid), 64'd0);
    check({tag, "_locked"},  64'(locked),     64'd0);
    check({tag, "_bad"},     64'(bad_period), 64'd0);
    check({tag, "_timeout"}, 64'(timeout),    64'd0);
  endtask

  always @(negedge clk_in) begin
    if (meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_meas_valid", 64'(meas_valid), 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        $display("meas: period=%0d div_out=%0d bad=%0b locked=%0b (want %0d/%0d/%0b/%0b)",
                 period, div_out, bad_period, locked, mon_e.p, mon_e.d, mon_e.b, mon_e.l);
        check("meas_period", 64'(period),     64'(mon_e.p));
        check("meas_div",    64'(div_out),    64'(mon_e.d));
        check("meas_bad",    64'(bad_period), 64'(mon_e.b));
        check("meas_locked", 64'(locked),     64'(mon_e.l));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_in);
    #1;
    check_zero("reset");
    rst = 1'b0;
    cycles(2);
    enable = 1'b1;
    cycles(3);

    // div=3: lock on the 4th measurement (5th edge)
    push(8, 3, 0, 0, 3);
    push(8, 3, 0, 1, 1);
    run_clk(4, 8, 5);
    drain("s1_drain");
    check("s1_locked", 64'(locked), 64'd1);

    // switch to div=5 with a 12-cycle transitional period
    cycles(4);
    push(12, 3, 1, 0, 1);
    push(32, 5, 0, 0, 3);
    push(32, 5, 0, 1, 1);
    run_clk(16, 32, 5);
    drain("s2_drain");
    check("s2_locked", 64'(locked), 64'd1);

    // irregular period 12: bad, never locks, div_out held
    push(32, 5, 0, 1, 1);
    push(12, 5, 1, 0, 3);
    run_clk(5, 12, 4);
    drain("s3_drain");
    check("s3_locked", 64'(locked), 64'd0);
    check("s3_bad", 64'(bad_period), 64'd1);

    // lock at period 4, then stop clk_meas
    push(12, 5, 1, 0, 1);
    push(4, 2, 0, 0, 3);
    push(4, 2, 0, 1, 1);
    run_clk(2, 4, 5);
    drain("s4_drain");
    check("s4_locked", 64'(locked), 64'd1);
    cycles(40);
    check("s4_no_timeout_yet", 64'(timeout), 64'd0);
    cycles(40);
    check("s4_timeout", 64'(timeout), 64'd1);
    check("s4_timeout_unlock", 64'(locked), 64'd0);
    run_clk(2, 4, 1);
    check("s4_timeout_clear", 64'(timeout), 64'd0);
    push(4, 2, 0, 0, 3);
    push(4, 2, 0, 1, 1);
    run_clk(2, 4, 4);
    drain("s4_relock_drain");
    check("s4_relocked", 64'(locked), 64'd1);

    // div=1, then an edge exactly at cnt = MAX_PERIOD
    push(4, 2, 0, 1, 1);
    push(2, 1, 0, 0, 3);
    push(2, 1, 0, 1, 1);
    run_clk(1, 2, 5);
    push(64, 6, 0, 0, 1);
    cycles(62);
    run_clk(1, 2, 1);
    cycles(3);
    check("s5_max_delivered", 64'(exp_q.size()), 64'd0);
    check("s5_max_no_timeout", 64'(timeout), 64'd0);
    check("s5_max_period", 64'(period), 64'd64);
    push(5, 6, 1, 0, 1);
    push(4, 2, 0, 0, 3);
    push(4, 2, 0, 1, 1);
    run_clk(2, 4, 5);
    drain("s5_drain");
    check("s5_locked", 64'(locked), 64'd1);

    // asynchronous reset mid-measurement
    #2;
    rst = 1'b1;
    #1;
    check_zero("rst_mid");
    cycles(2);
    rst = 1'b0;
    push(4, 2, 0, 0, 3);
    push(4, 2, 0, 1, 1);
    run_clk(2, 4, 5);
    drain("s6_drain");
    check("s6_relocked", 64'(locked), 64'd1);

    // enable drop: outputs clear one cycle later, nothing measured while low
    enable = 1'b0;
    @(negedge clk_in);
    check("s7_locked_before_clear", 64'(locked), 64'd1);
    @(posedge clk_in);
    #1;
    check_zero("disable");
    run_clk(2, 4, 3);
    cycles(2);
    check_zero("disabled_run");
    enable = 1'b1;
    cycles(2);
    push(4, 2, 0, 0, 3);
    push(4, 2, 0, 1, 1);
    run_clk(2, 4, 5);
    drain("s7_drain");
    check("s7_relocked", 64'(locked), 64'd1);
    check("s7_div", 64'(div_out), 64'd2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
